// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;

    // Requester side: issues operations, consumes results.
    modport master (
        output in_valid, op, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, hi, lo, busy
    );

    // Unit side.
    modport slave (
        input  in_valid, op, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, hi, lo, busy
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, followed by a single sign-fixup cycle.
module ex_muldiv_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    ex_muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   opd_q;      // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   src_a_q;    // raw dividend, returned as remainder on divide-by-zero
    logic                is_div_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                div0_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                out_valid_q;

    logic                signed_op;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] step_next;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

    // Operand magnitudes at accept and one iteration step of the selected datapath.
    always_comb begin
        signed_op = bus.op[0];
        mag_a     = (signed_op && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
        mag_b     = (signed_op && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opd_q : '0)};

        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        // When div_ge holds the difference is below the divisor, so W bits suffice.
        div_rem   = div_ge ? (div_shift[DATA_W-1:0] - opd_q) : div_shift[DATA_W-1:0];

        if (is_div_q) begin
            step_next = {div_rem, acc_q[DATA_W-2:0], div_ge};
        end else begin
            step_next = {mul_sum, acc_q[DATA_W-1:1]};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        fix_hi = acc_q[2*DATA_W-1:DATA_W];
        fix_lo = acc_q[DATA_W-1:0];
        if (!is_div_q) begin
            if (neg_res_q) begin
                {fix_hi, fix_lo} = -acc_q;
            end
        end else if (div0_q) begin
            fix_hi = src_a_q;
            fix_lo = '1;
        end else begin
            if (neg_res_q) begin
                fix_lo = -acc_q[DATA_W-1:0];
            end
            if (neg_rem_q) begin
                fix_hi = -acc_q[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Control FSM and datapath registers; flush wins over accept and consume.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opd_q       <= '0;
            src_a_q     <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div0_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q   <= RUN;
                        cnt_q     <= CNT_W'(DATA_W - 1);
                        is_div_q  <= bus.op[1];
                        neg_res_q <= signed_op && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                        neg_rem_q <= signed_op && bus.src_a[DATA_W-1];
                        div0_q    <= bus.op[1] && (bus.src_b == '0);
                        src_a_q   <= bus.src_a;
                        acc_q     <= {{DATA_W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        opd_q     <= bus.op[1] ? mag_b : mag_a;
                    end
                end
                RUN: begin
                    acc_q <= step_next;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    state_q <= DONE;
                end
                DONE: begin
                    // Result registers settle on DONE entry; valid follows one edge later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = resetn && (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
